// File: rtl/reg_writeback_if.sv
// reg_writeback_if: bundles the signals that reg_writeback exchanges with its
// neighbours. These are the ALU and load producer handshakes, the register
// file write port, the decode bypass lookup, and the busy status.
//   slave  : the reg_writeback side. It takes the producer requests and the
//            lookup indices, and drives ready, the write port, fwd_* and busy.
//   master : the environment side (producers, register file, decode).
interface reg_writeback_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] chk_addr1;
  logic [ADDR_WIDTH-1:0] chk_addr2;
  logic                  fwd_hit1;
  logic                  fwd_hit2;
  logic [DATA_WIDTH-1:0] fwd_data1;
  logic [DATA_WIDTH-1:0] fwd_data2;
  logic                  busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           chk_addr1, chk_addr2,
    output alu_ready, mem_ready, wr_en, wr_addr, wr_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           chk_addr1, chk_addr2,
    input  alu_ready, mem_ready, wr_en, wr_addr, wr_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, busy
  );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: the write-side front end of the 32-entry register file.
// ALU and load results arrive over valid/ready handshakes, with the load unit
// taking priority. They are queued in a circular FIFO and drained into a
// registered write port at one write per cycle. The decode stage can look up
// results that are still pending through two bypass ports.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : reg_writeback_if.slave. It carries the alu_* and mem_* handshakes,
//          the wr_en/wr_addr/wr_data write port, the chk_addrN -> fwd_hitN and
//          fwd_dataN lookups, and busy.
// The DATA_WIDTH and ADDR_WIDTH parameters must match the interface instance.
module reg_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  reg_writeback_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NUM_CHK = 2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  wb_entry_t [FIFO_DEPTH-1:0] q;
  wb_entry_t                  push_ent;
  logic [PW-1:0]              wptr, rptr;
  logic [CW-1:0]              count;
  logic                       full, empty, fire, push, pop;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Ready depends only on the occupancy. A same-cycle pop never frees a slot.
  assign bus.mem_ready = !full;
  assign bus.alu_ready = !full && !bus.mem_valid;

  // Whichever producer wins arbitration, a transfer happens whenever the
  // queue is not full.
  assign fire     = !full && (bus.mem_valid || bus.alu_valid);
  assign push_ent = bus.mem_valid ? wb_entry_t'{bus.mem_rd, bus.mem_data}
                                  : wb_entry_t'{bus.alu_rd, bus.alu_data};
  // Writes to x0 complete the handshake and are then dropped.
  assign push     = fire && (push_ent.rd != '0);
  assign pop      = !empty;

  // The queue contents need no reset. The pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) q[wptr] <= push_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      bus.wr_en <= pop;
      if (pop) begin
        bus.wr_addr <= q[rptr].rd;
        bus.wr_data <= q[rptr].data;
      end
    end
  end

  assign bus.busy = !empty || bus.wr_en;

  // Bypass: the scan runs from oldest to newest (output register, head, ...,
  // tail), so the last match it sees is the newest pending value.
  logic [NUM_CHK-1:0][ADDR_WIDTH-1:0] chk;
  logic [NUM_CHK-1:0]                 hit;
  logic [NUM_CHK-1:0][DATA_WIDTH-1:0] hdata;

  assign chk[0] = bus.chk_addr1;
  assign chk[1] = bus.chk_addr2;

  always_comb begin
    hit   = '0;
    hdata = '0;
    for (int p = 0; p < NUM_CHK; p++) begin
      if (bus.wr_en && bus.wr_addr == chk[p]) begin
        hit[p]   = 1'b1;
        hdata[p] = bus.wr_data;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CW'(i) < count && q[rptr + PW'(i)].rd == chk[p]) begin
          hit[p]   = 1'b1;
          hdata[p] = q[rptr + PW'(i)].data;
        end
      end
      if (chk[p] == '0) begin
        hit[p]   = 1'b0;
        hdata[p] = '0;
      end
    end
  end

  assign bus.fwd_hit1  = hit[0];
  assign bus.fwd_hit2  = hit[1];
  assign bus.fwd_data1 = hdata[0];
  assign bus.fwd_data2 = hdata[1];
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed testbench for reg_writeback. The bench drives
// inputs just after the falling edge. It samples registered outputs at the
// falling edge, and combinational outputs #1 after it drives them.
module tb_reg_writeback;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reg_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.chk_addr1 = 5'd3; bus.chk_addr2 = 5'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
    checks++; if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_port got %0d/%h want 0/0", bus.wr_addr, bus.wr_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b want 11", bus.mem_ready, bus.alu_ready); end
    checks++; if (bus.fwd_hit1 !== 1'b0 || bus.fwd_data1 !== 32'd0) begin errors++; $display("FAIL reset_fwd got %b/%h want 0/0", bus.fwd_hit1, bus.fwd_data1); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hDEADBEEF;
    bus.chk_addr1 = 5'd3;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got %b want 1", bus.alu_ready); end
    checks++; if (bus.fwd_hit1 !== 1'b0) begin errors++; $display("FAIL single_fwd_same_cycle got %b want 0", bus.fwd_hit1); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL single_wr_en_early got %b want 0", bus.wr_en); end
    checks++; if (bus.fwd_hit1 !== 1'b1 || bus.fwd_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd_queued got %b/%h want 1/deadbeef", bus.fwd_hit1, bus.fwd_data1); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3 || bus.wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write got %b/%0d/%h want 1/3/deadbeef", bus.wr_en, bus.wr_addr, bus.wr_data); end
    checks++; if (bus.fwd_hit1 !== 1'b1 || bus.fwd_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd_outreg got %b/%h want 1/deadbeef", bus.fwd_hit1, bus.fwd_data1); end
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_done got wr_en %b busy %b want 0 0", bus.wr_en, bus.busy); end
    checks++; if (bus.fwd_hit1 !== 1'b0 || bus.fwd_data1 !== 32'd0) begin errors++; $display("FAIL single_fwd_clear got %b/%h want 0/0", bus.fwd_hit1, bus.fwd_data1); end
    checks++; if (bus.wr_addr !== 5'd3 || bus.wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold got %0d/%h want 3/deadbeef", bus.wr_addr, bus.wr_data); end
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd5; bus.mem_data = 32'h11;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h22;
    #1;
    checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL arb_ready got mem %b alu %b want 1 0", bus.mem_ready, bus.alu_ready); end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL arb_alu_ready got %b want 1", bus.alu_ready); end
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 32'h11) begin errors++; $display("FAIL arb_write1 got %b/%0d/%h want 1/5/11", bus.wr_en, bus.wr_addr, bus.wr_data); end
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd6 || bus.wr_data !== 32'h22) begin errors++; $display("FAIL arb_write2 got %b/%0d/%h want 1/6/22", bus.wr_en, bus.wr_addr, bus.wr_data); end
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL arb_idle got %b want 0", bus.wr_en); end
  endtask

  task automatic test_burst_wrap();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      // Item j is transferred at the edge after falling edge j-1 and is seen
      // on the write port at falling edge j+1.
      if (k >= 2 && k <= 13) begin
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'(k - 1) || bus.wr_data !== 32'((k - 1) * 32'h100)) begin
          errors++; $display("FAIL burst_write k=%0d got %b/%0d/%h want 1/%0d/%h", k, bus.wr_en, bus.wr_addr, bus.wr_data, k - 1, (k - 1) * 32'h100);
        end
      end else begin
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL burst_idle k=%0d got %b want 0", k, bus.wr_en); end
      end
      if (k < 12) begin
        bus.mem_valid = 1'b1; bus.mem_rd = 5'(k + 1); bus.mem_data = 32'((k + 1) * 32'h100);
        #1;
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL burst_mem_ready k=%0d got %b want 1", k, bus.mem_ready); end
      end else begin
        idle_inputs();
      end
    end
  endtask

  task automatic test_x0_discard();
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF;
    bus.chk_addr1 = 5'd0;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", bus.alu_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin errors++; $display("FAIL x0_queued got busy %b wr_en %b want 0 0", bus.busy, bus.wr_en); end
    checks++; if (bus.fwd_hit1 !== 1'b0) begin errors++; $display("FAIL x0_fwd got %b want 0", bus.fwd_hit1); end
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL x0_write got wr_en %b busy %b want 0 0", bus.wr_en, bus.busy); end
  endtask

  task automatic test_bypass_newest();
    logic [31:0] exp_d [0:4];
    exp_d[0] = 32'h0; exp_d[1] = 32'hA; exp_d[2] = 32'hB; exp_d[3] = 32'hC; exp_d[4] = 32'hC;
    bus.chk_addr1 = 5'd7; bus.chk_addr2 = 5'd7;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      idle_inputs();
      case (k)
        0: begin bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'hA; end
        1: begin bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'hB; end
        2: begin bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'hC; end
        default: ;
      endcase
      #1;
      if (k >= 1 && k <= 4) begin
        checks++; if (bus.fwd_hit1 !== 1'b1 || bus.fwd_data1 !== exp_d[k]) begin errors++; $display("FAIL bypass_newest k=%0d got %b/%h want 1/%h", k, bus.fwd_hit1, bus.fwd_data1, exp_d[k]); end
        checks++; if (bus.fwd_hit2 !== 1'b1 || bus.fwd_data2 !== exp_d[k]) begin errors++; $display("FAIL bypass_port2 k=%0d got %b/%h want 1/%h", k, bus.fwd_hit2, bus.fwd_data2, exp_d[k]); end
      end else begin
        checks++; if (bus.fwd_hit1 !== 1'b0 || bus.fwd_data1 !== 32'd0) begin errors++; $display("FAIL bypass_idle k=%0d got %b/%h want 0/0", k, bus.fwd_hit1, bus.fwd_data1); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.chk_addr1 = 5'd10; bus.chk_addr2 = 5'd9;
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h1010;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd9 || bus.fwd_hit1 !== 1'b1) begin errors++; $display("FAIL rstmid_setup got wr_en %b addr %0d hit1 %b want 1 9 1", bus.wr_en, bus.wr_addr, bus.fwd_hit1); end
    #1;
    rst = 1'b1;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'h44;
    #1;
    checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_async got wr_en %b busy %b want 0 0", bus.wr_en, bus.busy); end
    checks++; if (bus.fwd_hit1 !== 1'b0 || bus.fwd_hit2 !== 1'b0) begin errors++; $display("FAIL rstmid_fwd got %b%b want 00", bus.fwd_hit1, bus.fwd_hit2); end
    checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got mem %b alu %b want 1 0", bus.mem_ready, bus.alu_ready); end
    checks++; if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin errors++; $display("FAIL rstmid_port got %0d/%h want 0/0", bus.wr_addr, bus.wr_data); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_stale k=%0d got wr_en %b busy %b want 0 0", k, bus.wr_en, bus.busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_arbitration();
    test_burst_wrap();
    test_x0_discard();
    test_bypass_newest();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
